muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer in the Execute stage, beside the single-cycle ALU. It accepts one M-extension operation per request and iterates a shift-add or restoring-divide datapath for XLEN cycles. It then returns the result through a valid/ready handshake. It holds the pipeline stall (busy_o) while occupied and is killed by a pipeline flush.

Parameters:
XLEN, 32, operand/result width; must equal DATA_WIDTH.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
req_valid_i  input  1  operation request
req_ready_o  output  1  high only in IDLE; request accepted when req_valid_i & req_ready_o
op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand1_i  input  XLEN  rs1 value (sampled at accept)
operand2_i  input  XLEN  rs2 value (sampled at accept)
flush_i  input  1  abort current operation
res_valid_o  output  1  result available
res_ready_i  input  1  consumer takes result
result_o  output  XLEN  result; stable while res_valid_o & !res_ready_i
busy_o  output  1  high in any state other than IDLE; drives Execute-stage stall

Behaviour:
- States: IDLE, CALC, FIX, DONE. The state and all outputs are registered.
- Reset: state=IDLE, req_ready_o=1, res_valid_o=0, busy_o=0, result_o=0, counter=0.
- IDLE, on accept:
  - Latch the op.
  - Latch the magnitudes of the operands. An operand is signed for MUL/MULH/DIV/REM (both), MULHSU (operand1 only); all other cases are unsigned.
  - Latch the result-sign flag:
    - mul: sign1 XOR sign2.
    - div: sign1 XOR sign2.
    - rem: sign1.
  - Load counter=XLEN and go to CALC.
- Special cases at accept go straight to DONE, with result_o loaded at the same edge:
  - Divisor zero: DIV/DIVU gives all-ones; REM/REMU gives operand1.
  - Signed overflow, DIV/REM with operand1=0x80000000 and operand2=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC:
  - Performs one iteration per cycle and decrements the counter.
  - Multiply: 2*XLEN-bit accumulator, shift-add of the multiplier LSB.
  - Divide: restoring; shift the remainder left by 1, subtract the divisor, set the quotient bit when the difference is non-negative, otherwise restore.
  - When the counter reaches 1, go to FIX.
- FIX (1 cycle):
  - Two's-complement negate the magnitude result if the sign flag is set.
  - Select the output: MUL takes the low XLEN of the product; MULH/MULHSU/MULHU take the high XLEN; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Load result_o, set res_valid_o, go to DONE.
- Latency: res_valid_o first high XLEN+2 cycles after the accept edge (34 for XLEN=32). For special cases it is 1 cycle after the accept edge.
- DONE: hold res_valid_o and result_o until res_valid_o & res_ready_i, then return to IDLE next cycle. req_ready_o is high only from the following cycle, so there is no same-cycle re-accept.
- flush_i in any non-IDLE state:
  - Next state IDLE, res_valid_o=0, result discarded.
  - flush_i takes priority over res_ready_i and over counter expiry in the same cycle.
- flush_i in IDLE with req_valid_i: flush wins and no accept occurs.
- Reset mid-operation: identical to the reset values; in-flight result lost.
- req_valid_i while busy: ignored (req_ready_o=0). Operand inputs are don't-care after accept.

Optional Feature:
MULDIV_RADIX4_MUL_EN.
- Defined: multiply retires 2 multiplier bits per CALC cycle, so the counter loads XLEN/2 for mul ops. Multiply latency becomes XLEN/2+2 (18). Divide is unchanged.
- Undefined: radix-2 multiply, latency XLEN+2.
- Results are bit-identical in both builds.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> result_o=0xFFFFFFEB; res_valid_o rises exactly 34 cycles after accept (18 with MULDIV_RADIX4_MUL_EN); busy_o high throughout.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD. REM -7%2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100%7 -> 2. Each with 34-cycle latency.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. All four: res_valid_o 1 cycle after accept.
- Back-pressure: hold res_ready_i=0 for 5 cycles after valid -> result_o/res_valid_o stable, req_ready_o=0. Raise res_ready_i -> IDLE next cycle, then a new request is accepted.
- Assert flush_i at CALC cycle 10 -> IDLE next cycle, res_valid_o never rises, a new request is accepted. Assert rst_i at CALC cycle 20 -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, valid/ready result.
// Optional build macro MULDIV_RADIX4_MUL_EN retires two multiplier bits per CALC cycle.

module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    cond_neg = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
    cond_neg2 = neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opb_q, opb_d;       // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;       // {hi, lo}: product, or {remainder, dividend/quotient}
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              res_valid_q, res_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;

  logic              accept_s;
  logic              sgn1_s, sgn2_s;
  logic              neg1_s, neg2_s;
  logic [XLEN-1:0]   mag1_s, mag2_s;
  logic              res_neg_s;
  logic              div_zero_s, ovf_s;
  logic [XLEN-1:0]   special_res_s;
  logic [CNT_W-1:0]  cnt_load_s;
  logic [2*XLEN-1:0] mul_acc_s, div_acc_s, prod_s;
  logic [XLEN:0]     rem_sh_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   div_diff_s;
  logic [XLEN-1:0]   fix_res_s;
`ifdef MULDIV_RADIX4_MUL_EN
  logic [XLEN+1:0]   pp_s;
  logic [XLEN+1:0]   mul_sum_s;
`else
  logic [XLEN:0]     mul_sum_s;
`endif

  assign accept_s = req_valid_i & req_ready_q & ~flush_i;

  // Operand signedness decode for the incoming request.
  always_comb begin
    sgn1_s = 1'b0;
    sgn2_s = 1'b0;
    case (op_i)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sgn1_s = 1'b1;
        sgn2_s = 1'b1;
      end
      OP_MULHSU: begin
        sgn1_s = 1'b1;
        sgn2_s = 1'b0;
      end
      default: begin
        sgn1_s = 1'b0;
        sgn2_s = 1'b0;
      end
    endcase
  end

  assign neg1_s     = sgn1_s & operand1_i[XLEN-1];
  assign neg2_s     = sgn2_s & operand2_i[XLEN-1];
  assign mag1_s     = cond_neg(operand1_i, neg1_s);
  assign mag2_s     = cond_neg(operand2_i, neg2_s);
  assign res_neg_s  = (op_i[2] & op_i[1]) ? neg1_s : (neg1_s ^ neg2_s);
  assign div_zero_s = op_i[2] & (operand2_i == ZERO);
  assign ovf_s      = ((op_i == OP_DIV) | (op_i == OP_REM)) &
                      (operand1_i == INT_MIN) & (operand2_i == ALL_ONES);

  // Results that bypass iteration: divide-by-zero and signed overflow.
  always_comb begin
    special_res_s = ZERO;
    if (div_zero_s) begin
      special_res_s = op_i[1] ? operand1_i : ALL_ONES;
    end else begin
      special_res_s = op_i[1] ? ZERO : INT_MIN;
    end
  end

`ifdef MULDIV_RADIX4_MUL_EN
  assign cnt_load_s = op_i[2] ? CNT_W'(XLEN) : CNT_W'(XLEN / 2);
  assign pp_s       = (acc_q[0] ? {2'b00, opb_q} : {(XLEN+2){1'b0}}) +
                      (acc_q[1] ? {1'b0, opb_q, 1'b0} : {(XLEN+2){1'b0}});
  assign mul_sum_s  = {2'b00, acc_q[2*XLEN-1:XLEN]} + pp_s;
  assign mul_acc_s  = {mul_sum_s, acc_q[XLEN-1:2]};
`else
  assign cnt_load_s = CNT_W'(XLEN);
  assign mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                      (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign mul_acc_s  = {mul_sum_s, acc_q[XLEN-1:1]};
`endif

  // Restoring step: the true difference is below the divisor, so XLEN bits hold it.
  assign rem_sh_s   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge_s   = rem_sh_s >= {1'b0, opb_q};
  assign div_diff_s = rem_sh_s[XLEN-1:0] - opb_q;
  assign div_acc_s  = div_ge_s ? {div_diff_s, acc_q[XLEN-2:0], 1'b1}
                               : {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  assign prod_s = cond_neg2(acc_q, neg_q);

  // Sign fix-up and result selection in FIX.
  always_comb begin
    fix_res_s = ZERO;
    case (op_q)
      OP_MUL:                       fix_res_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res_s = cond_neg(acc_q[XLEN-1:0], neg_q);
      OP_REM, OP_REMU:              fix_res_s = cond_neg(acc_q[2*XLEN-1:XLEN], neg_q);
      default:                      fix_res_s = ZERO;
    endcase
  end

  // Next-state and datapath control; flush dominates every non-IDLE transition.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d  = op_i;
          neg_d = res_neg_s;
          if (op_i[2]) begin
            opb_d = mag2_s;
            acc_d = {ZERO, mag1_s};
          end else begin
            opb_d = mag1_s;
            acc_d = {ZERO, mag2_s};
          end
          if (div_zero_s | ovf_s) begin
            state_d     = S_DONE;
            result_d    = special_res_s;
            res_valid_d = 1'b1;
            cnt_d       = {CNT_W{1'b0}};
          end else begin
            state_d = S_CALC;
            cnt_d   = cnt_load_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
        end else begin
          acc_d = op_q[2] ? div_acc_s : mul_acc_s;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIX: begin
        if (flush_i) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end else begin
          state_d     = S_DONE;
          result_d    = fix_res_s;
          res_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (flush_i) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end else if (res_ready_i) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b000;
      opb_q       <= ZERO;
      acc_q       <= {(2*XLEN){1'b0}};
      neg_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      result_q    <= ZERO;
      res_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign res_valid_o = res_valid_q;
  assign result_o    = result_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model, per-cycle compare, directed and random ops.

module tb_muldiv_seq;

  localparam int XLEN = 32;
`ifdef MULDIV_RADIX4_MUL_EN
  localparam int MUL_LAT = 18;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready_o;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        flush;
  logic        res_valid_o;
  logic        res_ready;
  logic [31:0] result_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .op_i        (op),
    .operand1_i  (opa),
    .operand2_i  (opb),
    .flush_i     (flush),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    r  = 64'h0;
    ref_result = 32'h0;
    case (o)
      3'b000: begin r = sa * sb; ref_result = r[31:0];  end
      3'b001: begin r = sa * sb; ref_result = r[63:32]; end
      3'b010: begin r = sa * ub; ref_result = r[63:32]; end
      3'b011: begin r = ua * ub; ref_result = r[63:32]; end
      3'b100: if (b == 32'h0) ref_result = 32'hFFFFFFFF; else begin r = sa / sb; ref_result = r[31:0]; end
      3'b101: if (b == 32'h0) ref_result = 32'hFFFFFFFF; else begin r = ua / ub; ref_result = r[31:0]; end
      3'b110: if (b == 32'h0) ref_result = a; else begin r = sa % sb; ref_result = r[31:0]; end
      default: if (b == 32'h0) ref_result = a; else begin r = ua % ub; ref_result = r[31:0]; end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 32'h0) return 1;
    if ((o == 3'b100 || o == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    if (!o[2]) return MUL_LAT;
    return DIV_LAT;
  endfunction

  // Transaction-level model: busy from accept to handshake, valid after the op's latency.
  logic        m_busy, m_valid;
  logic [31:0] m_result, m_exp;
  int          m_age, m_lat;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_result <= 32'h0;
      m_age    <= 0;
    end else if (!m_busy) begin
      if (req_valid && !flush) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_lat  <= exp_latency(op, opa, opb);
        m_exp  <= ref_result(op, opa, opb);
        if (exp_latency(op, opa, opb) == 1) begin
          m_valid  <= 1'b1;
          m_result <= ref_result(op, opa, opb);
        end
      end
    end else if (flush) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (m_valid && res_ready) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      m_age <= m_age + 1;
      if (!m_valid && (m_age + 1 == m_lat - 1)) begin
        m_valid  <= 1'b1;
        m_result <= m_exp;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",      {31'h0, busy_o},      {31'h0, m_busy});
      chk("req_ready", {31'h0, req_ready_o}, {31'h0, !m_busy});
      chk("res_valid", {31'h0, res_valid_o}, {31'h0, m_valid});
      if (m_valid) chk("result", result_o, m_result);
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Present a request and return at the negedge after its accept edge.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int w;
    @(negedge clk);
    req_valid = 1'b1; op = o; opa = a; opb = b;
    w = 0;
    while (!req_ready_o && w < 60) begin
      @(negedge clk);
      w++;
    end
    ok = req_ready_o;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: req_ready_o stayed %b, required 1", req_ready_o);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    op = 3'($urandom); opa = $urandom; opb = $urandom;
  endtask

  task automatic recover();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold,
                       output int lat, output logic [31:0] res, output bit ok);
    start_op(o, a, b, ok);
    lat = 0; res = 32'h0;
    if (!ok) return;
    lat = 1;
    while (!res_valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!res_valid_o) begin
      n_cmp++; n_err++;
      $display("FAIL valid_timeout: res_valid_o stayed 0 after %0d cycles, required 1", lat);
      ok = 1'b0;
      recover();
      return;
    end
    res = result_o;
    repeat (hold) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run_directed(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] lit, input int lit_lat, input int hold);
    int lat; logic [31:0] res; bit ok;
    chk("model_pin", ref_result(o, a, b), lit);
    do_op(o, a, b, hold, lat, res, ok);
    if (ok) begin
      chk("lit_result", res, lit);
      chk("lit_latency", 32'(lat), 32'(lit_lat));
    end
  endtask

  task automatic run_random(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat; logic [31:0] res; bit ok;
    do_op(o, a, b, hold, lat, res, ok);
    if (ok) begin
      chk("rand_result", res, ref_result(o, a, b));
      chk("rand_latency", 32'(lat), 32'(exp_latency(o, a, b)));
    end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b, r;
    int          lat;
    int          hold;
  } vec_t;

  vec_t dir[12];

  initial begin
    bit ok;
    rst = 1'b1; req_valid = 1'b0; op = 3'b000; opa = 32'h0; opb = 32'h0;
    flush = 1'b0; res_ready = 1'b0;

    dir[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 0};
    dir[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 1};
    dir[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 0};
    dir[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 0};
    dir[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT, 0};
    dir[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT, 0};
    dir[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT, 5};
    dir[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT, 0};
    dir[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,       0};
    dir[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1,       2};
    dir[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,       0};
    dir[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,       0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_result",    result_o,               32'h0);
    chk("rst_req_ready", {31'h0, req_ready_o},   32'h1);
    chk("rst_res_valid", {31'h0, res_valid_o},   32'h0);
    chk("rst_busy",      {31'h0, busy_o},        32'h0);
    rst = 1'b0;

    foreach (dir[i]) run_directed(dir[i].o, dir[i].a, dir[i].b, dir[i].r, dir[i].lat, dir[i].hold);

    // Flush mid-CALC: nothing may be produced, then a fresh request goes through.
    start_op(3'b101, 32'd1000, 32'd3, ok);
    if (ok) begin
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy",      {31'h0, busy_o},      32'h0);
      chk("flush_req_ready", {31'h0, req_ready_o}, 32'h1);
      for (int k = 0; k < 40; k++) begin
        chk("flush_no_valid", {31'h0, res_valid_o}, 32'h0);
        @(negedge clk);
      end
    end
    run_directed(3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT, 0);

    // Flush and request together in IDLE: no accept.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; op = 3'b000; opa = 32'd3; opb = 32'd4;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("idle_flush_busy", {31'h0, busy_o}, 32'h0);

    // Flush beats res_ready in DONE.
    start_op(3'b101, 32'd9, 32'd0, ok);
    if (ok) begin
      flush = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; res_ready = 1'b0;
      chk("done_flush_valid", {31'h0, res_valid_o}, 32'h0);
    end

    // Reset mid-CALC.
    start_op(3'b000, 32'h12345678, 32'h9ABCDEF0, ok);
    if (ok) begin
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_result",    result_o,             32'h0);
      chk("mid_rst_req_ready", {31'h0, req_ready_o}, 32'h1);
      chk("mid_rst_res_valid", {31'h0, res_valid_o}, 32'h0);
      chk("mid_rst_busy",      {31'h0, busy_o},      32'h0);
      rst = 1'b0;
    end

    for (int n = 0; n < 80; n++) begin
      run_random(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
